// File: rtl/ifq_pkg.sv
// Shared defaults and the queue entry layout for the instruction fetch queue.
//   XLEN_DEF     : default instruction/address width
//   RESET_PC_DEF : default first fetch address after reset
//   PC_STEP      : byte distance between consecutive instruction words
//   ifq_entry_t  : one queue entry, {pc, instr}
package ifq_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP = 4;

  // Field order matches the flat {pc, instr} word stored in ifq_fifo.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Storage for the instruction fetch queue: DEPTH entries with a registered head.
//   clk, reset         : clock, asynchronous active-high reset
//   push, push_data    : write an entry at the tail
//   pop                : remove the head (ignored when empty)
//   flush              : discard all entries; overrides push and pop
//   count              : current occupancy
//   head_valid         : head entry present
//   head_data          : head entry, held while head_valid is low
module ifq_fifo import ifq_pkg::*; #(
  parameter int unsigned WIDTH = 2 * XLEN_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]    count_n, remain;
  logic             push_eff, pop_eff;
  logic [WIDTH-1:0] head_n;

  // Next pointers/occupancy; the head register is preloaded with whatever
  // will sit at the head after this edge, so pushed data never bypasses.
  always_comb begin
    pop_eff  = pop & (count != '0) & ~flush;
    push_eff = push & ~flush;
    remain   = count - CW'(pop_eff);
    count_n  = remain + CW'(push_eff);
    rd_ptr_n = rd_ptr + AW'(pop_eff);
    wr_ptr_n = wr_ptr + AW'(push_eff);
    head_n   = (remain == '0) ? push_data : mem[rd_ptr_n];
    if (flush) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end
  end

  // Entry array (no reset needed; only read once written).
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      if (count_n != '0) begin
        head_data <= head_n;
      end
    end
  end

  // Upstream credit accounting must never let a write land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_eff && !pop_eff && (count == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit
// limit, queues returned words with their PC, and flushes on redirect while
// discarding responses still in flight from the old path.
//   clk, reset                         : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready          : fetch request handshake
//   imem_rsp_valid/data                : in-order fetch responses
//   instr_valid/instr/instr_pc/ready   : queue head toward IF/ID
//   redirect, redirect_pc              : flush and restart at a new target
module ifetch_queue import ifq_pkg::*; #(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
  logic [XLEN-1:0]   rsp_pc, rsp_pc_n;
  logic [CW-1:0]     outstanding, outstanding_n;
  logic [CW-1:0]     drop_cnt, drop_cnt_n;
  logic [CW-1:0]     occupancy;
  logic [XLEN-1:0]   target;
  logic              accept, push;
  logic [2*XLEN-1:0] head;
  logic              unused_low_bits;

  assign target          = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // Queued plus in-flight words may never exceed the queue size.
  assign imem_req_valid = ~reset & ~redirect &
                          ((SW'(occupancy) + SW'(outstanding)) < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // Responses belonging to an abandoned path (drop_cnt > 0) are discarded;
  // a response arriving together with a redirect is stale as well.
  assign push = imem_rsp_valid & (drop_cnt == '0) & ~redirect;

  // Next-state for PCs, in-flight count and stale-response count.
  always_comb begin
    fetch_pc_n    = fetch_pc;
    rsp_pc_n      = rsp_pc;
    outstanding_n = outstanding;
    drop_cnt_n    = drop_cnt;

    case ({accept, imem_rsp_valid})
      2'b10:   outstanding_n = outstanding + CW'(1);
      2'b01:   outstanding_n = outstanding - CW'(1);
      default: outstanding_n = outstanding;
    endcase

    if (redirect) begin
      fetch_pc_n = target;
      rsp_pc_n   = target;
      drop_cnt_n = outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        fetch_pc_n = fetch_pc + XLEN'(PC_STEP);
      end
      if (push) begin
        rsp_pc_n = rsp_pc + XLEN'(PC_STEP);
      end
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt_n = drop_cnt - CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      rsp_pc      <= rsp_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
    end
  end

  ifq_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({rsp_pc, imem_rsp_data}),
    .pop        (instr_ready),
    .flush      (redirect),
    .count      (occupancy),
    .head_valid (instr_valid),
    .head_data  (head)
  );

  assign instr_pc = head[2*XLEN-1:XLEN];
  assign instr    = head[XLEN-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases push expected fetch
// addresses and expected {pc, instr} entries; a memory model and a monitor
// pop and compare as the DUT issues requests and presents instructions.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  int          acc_limit = 0;
  int          base;
  pend_t       pend[$];
  logic [31:0] exp_req[$];
  ifq_entry_t  exp_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_instr(input logic [31:0] a);
    exp_instr.push_back('{pc: a, instr: mem_word(a)});
  endtask

  // Memory model: fixed latency, in-order responses, checks each accept.
  always begin
    @(negedge clk);
    cyc = cyc + 1;
    if (reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #1;
    imem_req_ready = (acc_cnt < acc_limit);
    #1;
    if (!reset && imem_req_valid && imem_req_ready) begin
      acc_cnt++;
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got addr %h expected no request (cycle %0d)", imem_req_addr, cyc);
      end else begin
        check("req_addr", imem_req_addr, exp_req.pop_front());
      end
    end
  end

  // Monitor: every effective pop is compared against the scoreboard.
  always begin : monitor
    ifq_entry_t e;
    @(negedge clk);
    #2;
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (exp_instr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL instr_unexpected: got pc %h expected no instruction (cycle %0d)", instr_pc, cyc);
      end else begin
        e = exp_instr.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.instr);
      end
    end
  end

  task automatic end_phase(input string name);
    check({name, "_req_drained"}, 32'(exp_req.size()), 32'd0);
    check({name, "_instr_drained"}, 32'(exp_instr.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    acc_limit = acc_cnt;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({name, "_req_addr"}, imem_req_addr, RPC);
    check({name, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({name, "_instr"}, instr, 32'd0);
    check({name, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    check_reset_values("rst");

    // Streaming: 1-cycle memory, 8 sequential fetches
    @(negedge clk);
    reset = 1'b0; lat = 1; instr_ready = 1'b1; acc_limit = acc_cnt + 8;
    for (int k = 0; k < 8; k++) begin
      exp_req.push_back(32'(k * 4));
      expect_instr(32'(k * 4));
    end
    #2;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("lat_c0_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); #2;
    check("lat_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); #2;
    check("lat_c2_valid", 32'(instr_valid), 32'd1);
    check("lat_c2_pc", instr_pc, 32'h0);
    repeat (10) @(negedge clk); #2;
    check("stream_idle_valid", 32'(instr_valid), 32'd0);
    end_phase("stream");

    // Stall: credits cap requests at DEPTH, then drain in order
    do_reset();
    @(negedge clk);
    reset = 1'b0; lat = 1; instr_ready = 1'b0; base = acc_cnt; acc_limit = acc_cnt + 8;
    for (int k = 0; k < 8; k++) begin
      exp_req.push_back(32'(k * 4));
      expect_instr(32'(k * 4));
    end
    repeat (9) @(negedge clk); #2;
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    check("full_accepts", 32'(acc_cnt - base), 32'(DEPTH));
    check("full_head_pc", instr_pc, 32'h0);
    @(negedge clk);
    instr_ready = 1'b1;
    repeat (15) @(negedge clk); #2;
    end_phase("stall");

    // Redirect with two responses in flight (3-cycle memory)
    do_reset();
    @(negedge clk);
    reset = 1'b0; lat = 3; instr_ready = 1'b1; acc_limit = acc_cnt + 4;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    expect_instr(32'h100); expect_instr(32'h104);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h103;
    #2;
    check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("redir_resume_valid", 32'(imem_req_valid), 32'd1);
    check("redir_resume_addr", imem_req_addr, 32'h100);
    repeat (9) @(negedge clk); #2;
    end_phase("redir");

    // Redirect coinciding with a response and a pop
    do_reset();
    @(negedge clk);
    reset = 1'b0; lat = 2; instr_ready = 1'b1; acc_limit = acc_cnt + 6;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    exp_req.push_back(32'h200); exp_req.push_back(32'h204);
    expect_instr(32'h0); expect_instr(32'h200); expect_instr(32'h204);
    repeat (4) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    #2;
    check("coinc_head_valid", 32'(instr_valid), 32'd1);
    check("coinc_head_pc", instr_pc, 32'h4);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("coinc_flushed", 32'(instr_valid), 32'd0);
    @(negedge clk); #2;
    check("coinc_no_stale", 32'(instr_valid), 32'd0);
    repeat (8) @(negedge clk); #2;
    end_phase("coinc");

    // Back-to-back redirects with responses in flight
    do_reset();
    @(negedge clk);
    reset = 1'b0; lat = 3; instr_ready = 1'b1; acc_limit = acc_cnt + 5;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h200); exp_req.push_back(32'h300); exp_req.push_back(32'h304);
    expect_instr(32'h300); expect_instr(32'h304);
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    repeat (11) @(negedge clk); #2;
    end_phase("b2b");

    // Reset mid-operation with words queued and in flight
    do_reset();
    @(negedge clk);
    reset = 1'b0; lat = 3; instr_ready = 1'b0; acc_limit = acc_cnt + 4;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    repeat (4) @(negedge clk); #2;
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_reset_values("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; lat = 1; instr_ready = 1'b1; acc_limit = acc_cnt + 1;
    exp_req.push_back(RPC);
    expect_instr(RPC);
    #2;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RPC);
    repeat (6) @(negedge clk); #2;
    end_phase("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
